mult_arbiter: RTL and testbench
===============================

MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter N, default 4: operand width; product width 2*N; matches the shared bit-pair multiplier.
REQ-002 Parameter TIMEOUT_CYC, default 4*N: WAIT-state cycle limit (used only when MULT_ARB_TIMEOUT_EN is defined).
REQ-003 Clocking: one clock, clk; reset rst, asynchronous, active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  async active-low reset.
REQ-006 req0_valid / req1_valid  input  1  requester has operands.
REQ-007 req0_ready / req1_ready  output  1  operands accepted this cycle.
REQ-008 req0_a, req0_b, req1_a, req1_b  input  N  multiplicand / multiplier per requester.
REQ-009 mul_start  output  1  one-cycle start pulse to the multiplier.
REQ-010 mul_multiplican, mul_multiplier  output  N  operands to the multiplier.
REQ-011 mul_busy, mul_done  input  1  multiplier status.
REQ-012 mul_product  input  2*N  multiplier result.
REQ-013 rsp_valid  output  1  result available.
REQ-014 rsp_ready  input  1  consumer accepts result.
REQ-015 rsp_id  output  1  requester index of result.
REQ-016 rsp_product  output  2*N  registered result.
REQ-017 rsp_err  output  1  timeout flag, qualified by rsp_valid.

Function
REQ-018 FSM states IDLE, LAUNCH, WAIT, RESP; one job in flight.
REQ-019 IDLE: if any req valid and mul_busy=0, grant one requester, assert its ready for exactly that cycle, latch its operands and id, go to LAUNCH.
REQ-020 Both valid: grant requester selected by round-robin pointer; one valid: grant it regardless of pointer.
REQ-021 Pointer moves to the non-granted index on each grant.
REQ-022 IDLE with mul_busy=1: no grant, no ready.
REQ-023 LAUNCH: mul_start=1 for one cycle; go to WAIT next cycle.
REQ-024 mul_multiplican/mul_multiplier hold latched operands from LAUNCH until WAIT exit.
REQ-025 WAIT: on mul_done=1, capture mul_product into rsp_product, go to RESP; mul_done outside WAIT ignored.
REQ-026 RESP: rsp_valid=1, outputs stable until rsp_ready=1; on that handshake go to IDLE.
REQ-027 Minimum latency: grant cycle T, mul_start at T+1, rsp_valid the cycle after mul_done seen.
REQ-028 New grant permitted in the IDLE cycle following the response handshake; no back-to-back overlap.

Reset
REQ-029 rst low: state IDLE, pointer=0, all outputs 0 (ready, mul_start, rsp_valid, rsp_err, operand and product registers).
REQ-030 Reset mid-operation: job discarded, no response issued; multiplier completion after reset ignored.

Configuration
REQ-031 MULT_ARB_TIMEOUT_EN defined: cycle counter runs in WAIT; at TIMEOUT_CYC cycles without mul_done go to RESP with rsp_err=1, rsp_product=0.
REQ-032 MULT_ARB_TIMEOUT_EN undefined: no counter, rsp_err tied 0, WAIT unbounded.

Structure
REQ-033 Shared package mult_arb_pkg: FSM state encoding, requester-id width, default TIMEOUT_CYC expression.
REQ-034 One sub-module rr_arb2: two-input round-robin grant with pointer register.

Verification
REQ-035 N=4, req0 a=3 b=-2 alone -> req0_ready one cycle, mul_start one cycle later, rsp_id=0, rsp_product=8'hFA.
REQ-036 Both valid at reset (pointer 0), a/b=2,3 and -4,5 -> first rsp_id=0 product 6, then rsp_id=1 product 8'hEC.
REQ-037 rsp_ready low 10 cycles -> rsp_valid and rsp_product stable, no new grant, req1_ready stays 0.
REQ-038 rst low during WAIT, then mul_done pulses -> no rsp_valid; next request served normally from pointer 0.
REQ-039 mul_busy=1 in IDLE with req valid -> no ready until busy drops; spurious mul_done in IDLE -> no response.
REQ-040 MULT_ARB_TIMEOUT_EN, no mul_done for TIMEOUT_CYC=16 cycles -> rsp_valid with rsp_err=1, rsp_product=0.

Source files
------------

// File: rtl/mult_arb_pkg.sv
// Shared definitions for the two-requester multiplier arbiter:
// FSM state encoding, requester-id width and the default WAIT timeout.
package mult_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } arb_state_t;

    // Two requesters, so a single bit identifies the owner of a job
    localparam int ID_W = 1;

    // Default WAIT limit scales with operand width (bit-pair multiplier needs ~N/2 steps)
    function automatic int default_timeout(input int n);
        return 4 * n;
    endfunction

endpackage

// File: rtl/mult_arb_if.sv
// Bundle of request, multiplier and response signals around mult_arbiter.
// slave  : the arbiter's view (accepts requests, drives the multiplier, returns results)
// master : the environment's view (requesters, multiplier, result consumer)
interface mult_arb_if import mult_arb_pkg::*; #(
    parameter int N = 4
);
    logic            req0_valid;
    logic            req1_valid;
    logic            req0_ready;
    logic            req1_ready;
    logic [N-1:0]    req0_a;
    logic [N-1:0]    req0_b;
    logic [N-1:0]    req1_a;
    logic [N-1:0]    req1_b;

    logic            mul_start;
    logic [N-1:0]    mul_multiplican;
    logic [N-1:0]    mul_multiplier;
    logic            mul_busy;
    logic            mul_done;
    logic [2*N-1:0]  mul_product;

    logic            rsp_valid;
    logic            rsp_ready;
    logic [ID_W-1:0] rsp_id;
    logic [2*N-1:0]  rsp_product;
    logic            rsp_err;

    modport slave (
        input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
        output req0_ready, req1_ready,
        output mul_start, mul_multiplican, mul_multiplier,
        input  mul_busy, mul_done, mul_product,
        output rsp_valid, rsp_id, rsp_product, rsp_err,
        input  rsp_ready
    );

    modport master (
        output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
        input  req0_ready, req1_ready,
        input  mul_start, mul_multiplican, mul_multiplier,
        output mul_busy, mul_done, mul_product,
        input  rsp_valid, rsp_id, rsp_product, rsp_err,
        output rsp_ready
    );

endinterface

// File: rtl/mult_arbiter_rr_arb2.sv
// rr_arb2: two-input round-robin arbiter. The pointer names the requester
// that wins a tie; after every grant it moves to the other requester.
module rr_arb2 import mult_arb_pkg::*; (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      req,
    input  logic            grant_en,
    output logic [1:0]      gnt,
    output logic [ID_W-1:0] gnt_id
);

    logic ptr;

    // Tie goes to the pointer; a lone requester wins regardless of the pointer
    always_comb begin
        gnt_id = '0;
        gnt    = 2'b00;
        if (req == 2'b11) begin
            gnt_id = ptr;
        end else begin
            gnt_id = req[1];
        end
        if (|req) begin
            gnt = gnt_id[0] ? 2'b10 : 2'b01;
        end
    end

    // Pointer hands priority to the loser of each accepted grant
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= 1'b0;
        end else if (grant_en && (|req)) begin
            ptr <= ~gnt_id[0];
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// mult_arbiter: shares one multiplier between two requesters, one job at a time.
// IDLE -> LAUNCH (start pulse) -> WAIT (for mul_done) -> RESP (hold until taken).
// Optional feature: define MULT_ARB_TIMEOUT_EN to bound WAIT to TIMEOUT_CYC cycles,
// after which the job is answered with rsp_err=1 and a zero product.
module mult_arbiter import mult_arb_pkg::*; #(
    parameter int N           = 4,
    parameter int TIMEOUT_CYC = default_timeout(N)
) (
    input  logic       clk,
    input  logic       rst,
    mult_arb_if.slave  bus
);

    arb_state_t      state;
    arb_state_t      state_next;
    logic            grant_en;
    logic [1:0]      req_vec;
    logic [1:0]      gnt;
    logic [ID_W-1:0] gnt_id;
    logic [N-1:0]    op_a;
    logic [N-1:0]    op_b;
    logic [ID_W-1:0] job_id;
    logic [2*N-1:0]  product_q;
    logic            timeout_hit;

    assign req_vec  = {bus.req1_valid, bus.req0_valid};

    // Grants only happen in IDLE with the multiplier free; held off while reset is asserted
    assign grant_en = (state == ST_IDLE) && !bus.mul_busy && rst;

    rr_arb2 u_rr (
        .clk      (clk),
        .rst      (rst),
        .req      (req_vec),
        .grant_en (grant_en),
        .gnt      (gnt),
        .gnt_id   (gnt_id)
    );

    assign bus.req0_ready      = grant_en && gnt[0];
    assign bus.req1_ready      = grant_en && gnt[1];
    assign bus.mul_start       = (state == ST_LAUNCH);
    assign bus.mul_multiplican = op_a;
    assign bus.mul_multiplier  = op_b;
    assign bus.rsp_valid       = (state == ST_RESP);
    assign bus.rsp_id          = job_id;
    assign bus.rsp_product     = product_q;

`ifdef MULT_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             err_q;

    // Counts cycles spent in WAIT; restarts from zero on every entry
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else if (state == ST_WAIT) begin
            wait_cnt <= wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

    assign timeout_hit = (state == ST_WAIT) && !bus.mul_done &&
                         (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

    // Error flag records whether the current response came from a timeout
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (state == ST_WAIT) begin
            if (bus.mul_done) begin
                err_q <= 1'b0;
            end else if (timeout_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.rsp_err = err_q;
`else
    assign timeout_hit = 1'b0;
    assign bus.rsp_err = 1'b0;
`endif

    // State register; reset abandons any job in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; mul_done only matters while waiting on our own job
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (grant_en && (|req_vec)) begin
                    state_next = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.mul_done || timeout_hit) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Operand and id capture at grant, product capture at completion
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_a      <= '0;
            op_b      <= '0;
            job_id    <= '0;
            product_q <= '0;
        end else begin
            if (grant_en && (|req_vec)) begin
                op_a   <= gnt_id[0] ? bus.req1_a : bus.req0_a;
                op_b   <= gnt_id[0] ? bus.req1_b : bus.req0_b;
                job_id <= gnt_id;
            end
            if (state == ST_WAIT) begin
                if (bus.mul_done) begin
                    product_q <= bus.mul_product;
                end else if (timeout_hit) begin
                    product_q <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter (N=4, TIMEOUT_CYC=16).
// A behavioural signed multiplier answers mul_start; a scoreboard holds the
// operands each launch must carry and the response each job must return.
// Honours MULT_ARB_TIMEOUT_EN to select the timeout or unbounded-wait scenario.
module tb_mult_arbiter;

    localparam int N       = 4;
    localparam int TO_CYC  = 16;
    localparam int MUL_LAT = 2;

    typedef struct {
        logic       id;
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] prod;
        logic       err;
    } job_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mult_arb_if #(.N(N)) bus ();

    mult_arbiter #(.N(N), .TIMEOUT_CYC(TO_CYC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_pass   = 0;
    job_t op_q[$];
    job_t exp_q[$];

    logic       model_busy    = 1'b0;
    logic       model_done    = 1'b0;
    logic       force_busy    = 1'b0;
    logic       spurious_done = 1'b0;
    logic       auto_done     = 1'b1;
    logic [7:0] model_prod    = 8'h00;
    logic [3:0] m_a;
    logic [3:0] m_b;
    int         m_cnt         = 0;
    bit         m_active      = 1'b0;
    bit         done_pending  = 1'b0;

    assign bus.mul_busy    = model_busy | force_busy;
    assign bus.mul_done    = model_done | spurious_done;
    assign bus.mul_product = model_prod;

    // Expected signed product computed with plain integers
    function automatic logic [7:0] smul(input logic [3:0] a, input logic [3:0] b);
        int ia;
        int ib;
        ia = a[3] ? int'(a) - 16 : int'(a);
        ib = b[3] ? int'(b) - 16 : int'(b);
        return 8'(ia * ib);
    endfunction

    // Behavioural multiplier: busy for a few cycles after start, then one done pulse
    always @(posedge clk) begin
        #1;
        model_done = 1'b0;
        if (!rst) begin
            model_busy = 1'b0;
            m_active   = 1'b0;
        end else if (m_active) begin
            if (m_cnt == 0) begin
                m_active   = 1'b0;
                model_busy = 1'b0;
                if (auto_done) begin
                    model_done = 1'b1;
                    model_prod = $signed(m_a) * $signed(m_b);
                end
            end else begin
                m_cnt = m_cnt - 1;
            end
        end else if (bus.mul_start === 1'b1) begin
            m_active   = 1'b1;
            model_busy = 1'b1;
            m_cnt      = MUL_LAT;
            m_a        = bus.mul_multiplican;
            m_b        = bus.mul_multiplier;
        end
    end

    // Scoreboard monitor: launch operands, response contents and done-to-valid latency
    always @(negedge clk) begin
        job_t j;
        if (!rst) begin
            done_pending = 1'b0;
        end else begin
            if (done_pending) begin
                n_checks++;
                if (bus.rsp_valid !== 1'b1)
                    $display("[TB] FAIL done_to_valid: rsp_valid=%b, expected 1", bus.rsp_valid);
                else
                    n_pass++;
                done_pending = 1'b0;
            end
            if (bus.mul_start === 1'b1) begin
                n_checks++;
                if (op_q.size() == 0) begin
                    $display("[TB] FAIL launch_unexpected: mul_start=1 with no job, expected 0");
                end else begin
                    j = op_q.pop_front();
                    if ({bus.mul_multiplican, bus.mul_multiplier} !== {j.a, j.b})
                        $display("[TB] FAIL launch_operands: a/b=%h/%h, expected %h/%h",
                                 bus.mul_multiplican, bus.mul_multiplier, j.a, j.b);
                    else
                        n_pass++;
                end
            end
            if (bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("[TB] FAIL rsp_unexpected: id=%0d product=%h, expected no response",
                             bus.rsp_id, bus.rsp_product);
                end else begin
                    j = exp_q.pop_front();
                    n_checks += 3;
                    if (bus.rsp_id !== j.id)
                        $display("[TB] FAIL rsp_id: got %0d, expected %0d", bus.rsp_id, j.id);
                    else
                        n_pass++;
                    if (bus.rsp_product !== j.prod)
                        $display("[TB] FAIL rsp_product: got %h, expected %h", bus.rsp_product, j.prod);
                    else
                        n_pass++;
                    if (bus.rsp_err !== j.err)
                        $display("[TB] FAIL rsp_err: got %b, expected %b", bus.rsp_err, j.err);
                    else
                        n_pass++;
                end
            end
            if (model_done === 1'b1) begin
                done_pending = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        force_busy     = 1'b0;
        spurious_done  = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
    endtask

    // Raise a request and record the launch (and optionally the response) it must cause
    task automatic drive_req(input bit which, input logic [3:0] a, input logic [3:0] b,
                             input bit expect_rsp, input bit err);
        job_t j;
        j.id   = which;
        j.a    = a;
        j.b    = b;
        j.err  = err;
        j.prod = err ? 8'h00 : smul(a, b);
        if (!which) begin
            bus.req0_a = a;
            bus.req0_b = b;
            bus.req0_valid = 1'b1;
        end else begin
            bus.req1_a = a;
            bus.req1_b = b;
            bus.req1_valid = 1'b1;
        end
        op_q.push_back(j);
        if (expect_rsp) exp_q.push_back(j);
    endtask

    task automatic wait_grant(input bit which, input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((which ? bus.req1_ready : bus.req0_ready) === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        tick();
        if (got) begin
            if (!which) bus.req0_valid = 1'b0;
            else        bus.req1_valid = 1'b0;
        end
    endtask

    task automatic wait_drain(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        #2;
        rst = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        bus.req0_a = 4'h5;
        bus.req0_b = 4'h6;
        bus.req1_a = 4'h7;
        bus.req1_b = 4'h1;
        tick();
        @(negedge clk);
        n_checks += 3;
        if ({bus.req0_ready, bus.req1_ready} !== 2'b00)
            $display("[TB] FAIL reset_ready: got %b, expected 00", {bus.req0_ready, bus.req1_ready});
        else n_pass++;
        if ({bus.mul_start, bus.rsp_valid, bus.rsp_err} !== 3'b000)
            $display("[TB] FAIL reset_ctrl: start/valid/err=%b, expected 000",
                     {bus.mul_start, bus.rsp_valid, bus.rsp_err});
        else n_pass++;
        if ({bus.mul_multiplican, bus.mul_multiplier, bus.rsp_product} !== 16'h0000)
            $display("[TB] FAIL reset_data: got %h, expected 0000",
                     {bus.mul_multiplican, bus.mul_multiplier, bus.rsp_product});
        else n_pass++;
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single();
        bit ok;
        bus.rsp_ready = 1'b1;
        drive_req(1'b0, 4'h3, 4'hE, 1'b1, 1'b0);
        @(negedge clk);
        n_checks++;
        if ({bus.req0_ready, bus.req1_ready, bus.mul_start} !== 3'b100)
            $display("[TB] FAIL single_grant: ready0/ready1/start=%b, expected 100",
                     {bus.req0_ready, bus.req1_ready, bus.mul_start});
        else n_pass++;
        tick();
        bus.req0_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus.req0_ready, bus.mul_start} !== 2'b01)
            $display("[TB] FAIL single_start: ready0/start=%b, expected 01",
                     {bus.req0_ready, bus.mul_start});
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (bus.mul_start !== 1'b0)
            $display("[TB] FAIL single_start_len: mul_start=%b, expected 0", bus.mul_start);
        else n_pass++;
        tick();
        wait_drain(40, ok);
        n_checks++;
        if (!ok) $display("[TB] FAIL single_drain: pending=%0d, expected 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_round_robin();
        bit got;
        bit ok;
        apply_reset();
        bus.rsp_ready = 1'b1;
        drive_req(1'b0, 4'h2, 4'h3, 1'b1, 1'b0);
        drive_req(1'b1, 4'hC, 4'h5, 1'b1, 1'b0);
        @(negedge clk);
        n_checks++;
        if ({bus.req0_ready, bus.req1_ready} !== 2'b10)
            $display("[TB] FAIL rr_first: ready0/ready1=%b, expected 10", {bus.req0_ready, bus.req1_ready});
        else n_pass++;
        tick();
        bus.req0_valid = 1'b0;
        wait_grant(1'b1, 40, got);
        n_checks += 2;
        if (!got) $display("[TB] FAIL rr_second_grant: got 0, expected 1");
        else n_pass++;
        if (exp_q.size() != 1)
            $display("[TB] FAIL rr_no_overlap: pending=%0d at second grant, expected 1", exp_q.size());
        else n_pass++;
        wait_drain(40, ok);
        n_checks++;
        if (!ok) $display("[TB] FAIL rr_drain: pending=%0d, expected 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_back_pressure();
        bit got;
        bit ok;
        int stable_bad;
        int ready_bad;
        bus.rsp_ready = 1'b0;
        drive_req(1'b0, 4'h1, 4'h7, 1'b1, 1'b0);
        wait_grant(1'b0, 10, got);
        drive_req(1'b1, 4'hF, 4'hF, 1'b1, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!ok) $display("[TB] FAIL bp_valid: rsp_valid never rose, expected 1");
        else n_pass++;
        stable_bad = 0;
        ready_bad  = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if ({bus.rsp_valid, bus.rsp_product, bus.rsp_id} !== {1'b1, 8'h07, 1'b0}) stable_bad++;
            if ({bus.req0_ready, bus.req1_ready, bus.mul_start} !== 3'b000) ready_bad++;
        end
        n_checks += 2;
        if (stable_bad != 0)
            $display("[TB] FAIL bp_stable: %0d unstable cycles, expected 0", stable_bad);
        else n_pass++;
        if (ready_bad != 0)
            $display("[TB] FAIL bp_no_grant: %0d cycles with ready/start, expected 0", ready_bad);
        else n_pass++;
        tick();
        bus.rsp_ready = 1'b1;
        wait_grant(1'b1, 20, got);
        n_checks++;
        if (!got) $display("[TB] FAIL bp_next_grant: got 0, expected 1");
        else n_pass++;
        wait_drain(40, ok);
        n_checks++;
        if (!ok) $display("[TB] FAIL bp_drain: pending=%0d, expected 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_busy();
        bit got;
        bit ok;
        int bad;
        bus.rsp_ready = 1'b1;
        force_busy = 1'b1;
        drive_req(1'b0, 4'hD, 4'h3, 1'b1, 1'b0);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            spurious_done = (i == 2);
            @(negedge clk);
            if ({bus.req0_ready, bus.rsp_valid, bus.mul_start} !== 3'b000) bad++;
            tick();
        end
        spurious_done = 1'b0;
        n_checks++;
        if (bad != 0) $display("[TB] FAIL busy_hold: %0d cycles with ready/valid/start, expected 0", bad);
        else n_pass++;
        force_busy = 1'b0;
        wait_grant(1'b0, 3, got);
        n_checks++;
        if (!got) $display("[TB] FAIL busy_release: got 0, expected 1");
        else n_pass++;
        wait_drain(40, ok);
        n_checks++;
        if (!ok) $display("[TB] FAIL busy_drain: pending=%0d, expected 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit got;
        bit ok;
        int bad;
        bus.rsp_ready = 1'b1;
        auto_done = 1'b0;
        drive_req(1'b0, 4'h2, 4'h2, 1'b0, 1'b0);
        wait_grant(1'b0, 10, got);
        repeat (3) tick();
        apply_reset();
        spurious_done = 1'b1;
        tick();
        spurious_done = 1'b0;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) $display("[TB] FAIL mid_reset_silent: %0d cycles rsp_valid=1, expected 0", bad);
        else n_pass++;
        tick();
        auto_done = 1'b1;
        drive_req(1'b0, 4'h7, 4'hF, 1'b1, 1'b0);
        drive_req(1'b1, 4'h8, 4'h8, 1'b1, 1'b0);
        @(negedge clk);
        n_checks++;
        if ({bus.req0_ready, bus.req1_ready} !== 2'b10)
            $display("[TB] FAIL mid_reset_ptr: ready0/ready1=%b, expected 10", {bus.req0_ready, bus.req1_ready});
        else n_pass++;
        tick();
        bus.req0_valid = 1'b0;
        wait_grant(1'b1, 40, got);
        wait_drain(40, ok);
        n_checks++;
        if (!(got && ok)) $display("[TB] FAIL mid_reset_drain: grant=%b drained=%b, expected 11", got, ok);
        else n_pass++;
    endtask

    task automatic test_timeout();
        bit got;
        bit ok;
        int cnt;
        bus.rsp_ready = 1'b1;
        auto_done = 1'b0;
`ifdef MULT_ARB_TIMEOUT_EN
        drive_req(1'b0, 4'h5, 4'h5, 1'b1, 1'b1);
        wait_grant(1'b0, 10, got);
        cnt = 0;
        ok  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            cnt++;
        end
        // One LAUNCH cycle plus sixteen WAIT cycles precede RESP
        n_checks++;
        if (!(ok && cnt == TO_CYC + 1))
            $display("[TB] FAIL timeout_latency: valid=%b after %0d cycles, expected 1 after %0d",
                     ok, cnt, TO_CYC + 1);
        else n_pass++;
        tick();
        wait_drain(10, ok);
        n_checks++;
        if (!ok) $display("[TB] FAIL timeout_drain: pending=%0d, expected 0", exp_q.size());
        else n_pass++;
`else
        drive_req(1'b0, 4'h5, 4'h5, 1'b0, 1'b0);
        wait_grant(1'b0, 10, got);
        repeat (30) tick();
        @(negedge clk);
        n_checks += 2;
        if (bus.rsp_valid !== 1'b0)
            $display("[TB] FAIL wait_unbounded: rsp_valid=%b, expected 0", bus.rsp_valid);
        else n_pass++;
        if (bus.rsp_err !== 1'b0)
            $display("[TB] FAIL err_tied: rsp_err=%b, expected 0", bus.rsp_err);
        else n_pass++;
        tick();
        apply_reset();
`endif
        auto_done = 1'b1;
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req0_a     = 4'h0;
        bus.req0_b     = 4'h0;
        bus.req1_a     = 4'h0;
        bus.req1_b     = 4'h0;
        bus.rsp_ready  = 1'b0;

        test_reset();
        test_single();
        test_round_robin();
        test_back_pressure();
        test_busy();
        test_reset_mid();
        test_timeout();

        repeat (3) tick();
        n_checks += 2;
        if (exp_q.size() != 0) $display("[TB] FAIL final_responses: pending=%0d, expected 0", exp_q.size());
        else n_pass++;
        if (op_q.size() != 0) $display("[TB] FAIL final_launches: pending=%0d, expected 0", op_q.size());
        else n_pass++;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
